// File: rtl/counter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// counter_pkg: shared types and widths for the counter enable path | Rev 1.0
// ---------------------------------------------------------------------------
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2
  } enable_gen_state_t;

  localparam logic MODE_CONTINUOUS = 1'b0;
  localparam logic MODE_BURST      = 1'b1;

  localparam int COUNTER_WIDTH = 8;
  localparam int DIV_WIDTH     = 8;

endpackage
`default_nettype wire

// File: rtl/counter_enable_gen_tick_divider.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_divider: programmable prescaler with a registered 1-cycle tick | Rev 1.0
// ---------------------------------------------------------------------------
module tick_divider #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 hit,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic                 tick_q, tick_d;

  // hit is the unregistered form of tick, so the owner of the burst
  // counter can update its state on the same edge the tick is issued.
  assign hit  = run && !clear && (presc_q == div);
  assign tick = tick_q;

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (clear) begin
      presc_d = '0;
    end else if (run) begin
      if (presc_q == div) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/counter_enable_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// counter_enable_gen: start/stop run controller producing counter enable ticks | Rev 1.0
// ---------------------------------------------------------------------------
module counter_enable_gen #(
  parameter int DIV_WIDTH   = counter_pkg::DIV_WIDTH,
  parameter int BURST_WIDTH = counter_pkg::COUNTER_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   burst_mode,
  input  logic [DIV_WIDTH-1:0]   divisor,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic                   enable,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [BURST_WIDTH-1:0] pulse_count
);

  import counter_pkg::*;

  enable_gen_state_t      state_q, state_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [BURST_WIDTH-1:0] len_q, len_d;
  logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;

  logic w_active;
  logic w_start_ok;
  logic w_run;
  logic w_clear;
  logic w_hit;

  assign w_active   = (state_q != ST_IDLE);
  assign w_start_ok = (state_q == ST_IDLE) && start && !stop;
  // Stop suppresses a tick even when the prescaler matches on that edge.
  assign w_run      = w_active && !stop;
  assign w_clear    = (w_active && stop) || w_start_ok;

  tick_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .run   (w_run),
    .clear (w_clear),
    .div   (div_q),
    .hit   (w_hit),
    .tick  (enable)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_start_ok) begin
          cnt_d = '0;
          if (burst_mode == MODE_BURST) begin
            if (burst_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_BURST;
              div_d   = divisor;
              len_d   = burst_len;
            end
          end else begin
            state_d = ST_RUN;
            div_d   = divisor;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (w_hit) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BURST: begin
        if (stop) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (w_hit) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == len_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign busy        = w_active;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign pulse_count = cnt_q;

endmodule
`default_nettype wire
